fd_n_ctrl: RTL and testbench
============================

# fd_n_ctrl

Sequencing controller for the N-divider of the DLL feedback path. Owns the divider's modulus counter, drives the counter value and the active ratio to the FD_N output stage, and accepts ratio-change requests over a valid/ready handshake. A new ratio is applied only at a counter wrap, so the divided clock never produces a runt pulse. After each change, `settled` stays low for a fixed window so the loop controller can hold its phase update until the divider output is stable.

## Interface
- `N_RESET`, default 4'd8: active ratio after reset; legal range 2..15.
- `SETTLE_CYC`, default 8: number of `clk_out` cycles `settled` stays low after a ratio is applied; legal range 1..255.
- `clk_out` in 1: divider clock; all state updates on its rising edge.
- `rst_n` in 1: active-low reset, asynchronous assert, synchronous deassert.
- `n_req_valid` in 1: ratio-change request valid.
- `n_req_val` in 4: requested ratio N.
- `n_req_ready` out 1: controller can accept a request.
- `n_cur` out 4: active ratio, routed to FD_N `N`.
- `n_counter` out 4: modulus counter, routed to FD_N `N_counter`.
- `wrap` out 1: high during the cycle where `n_counter == n_cur`.
- `settled` out 1: divider stable at `n_cur`.
- `err` out 1: one-cycle pulse on a rejected request. Exists only with `FD_N_CTRL_RANGE_CHK_EN`.

## Operation
- Counter sequence: 1, 2, …, `n_cur`, then back to 1, giving a period of exactly `n_cur` cycles.
- States:
  - RUN: `n_req_ready`=1.
  - PEND: request latched into `n_pend`, waiting for a wrap.
  - SETTLE: counting down the settle window.
- RUN → PEND on `n_req_valid && n_req_ready`. `n_req_val` is captured into `n_pend` on that edge.
- PEND → SETTLE on the edge where `wrap`=1. On that edge: `n_cur` ← `n_pend`, `n_counter` ← 1, settle count ← `SETTLE_CYC`-1.
- SETTLE → RUN when the settle count reaches 0 (decrements once per cycle). The counter keeps running at the new ratio throughout.
- `n_req_ready`=0 in PEND and SETTLE. Requests presented there are not accepted, and the requester holds them.
- Accept on the same edge as a wrap: the new ratio applies at the next wrap, not the current one. Latency is deterministic.
- `n_req_val` == `n_cur`: the full PEND/SETTLE sequence still runs, and the counter is resynchronised to 1 at the wrap.
- Values 0 and 1 are illegal. Handling depends on the Configuration macro.
- All counter and compare arithmetic is 4-bit unsigned. The settle counter is 8 bits.

## Timing
- Reset values: `n_cur`=`N_RESET`, `n_counter`=1, `wrap`=0, `settled`=1, `n_req_ready`=1, `err`=0, state RUN.
- `wrap` and `settled` are combinational decodes of registers: `wrap` = (`n_counter`==`n_cur`), `settled` = (state==RUN).
- Accept-to-apply latency: 1 to `n_cur` cycles after the accepting edge, always ending on the wrap edge.
- Apply-to-`settled`: `settled` rises exactly `SETTLE_CYC` cycles after the apply edge.
- `rst_n` asserted mid-PEND or mid-SETTLE discards `n_pend` and returns to reset values immediately, without waiting for a clock edge.

## Configuration
- With `FD_N_CTRL_RANGE_CHK_EN` defined:
  - A request with `n_req_val` < 2 completes the handshake, because `n_req_ready` is high.
  - The request is discarded and `err` pulses for 1 cycle.
  - State stays RUN and `n_cur` is unchanged.
- Without the macro:
  - The `err` port is absent.
  - Values < 2 are clamped to 2 at capture and follow the normal sequence.

## Structure
- Shared package `fd_n_pkg`:
  - state enum `fd_ctrl_state_t` {RUN, PEND, SETTLE};
  - constants `FD_N_W`=4, `FD_N_MIN`=2, `FD_SETTLE_W`=8.
- One natural sub-module, `fd_n_modcnt`: the 1..N modulus counter with a synchronous load-to-1 input and the `wrap` decode. The controller FSM, request latch and settle timer stay in the top.

## Test plan
- Reset release, no requests: `n_counter` cycles 1..8, `wrap` high every 8th cycle, `settled`=1, `n_req_ready`=1.
- Request `n_req_val`=5, accepted at `n_counter`=3 with `n_cur`=8:
  - `n_cur` becomes 5 on the edge after the cycle with `n_counter`=8.
  - Counter restarts at 1.
  - `settled` is low for exactly 8 cycles; then the period is 5.
- Request accepted in the cycle where `wrap`=1: the current wrap is skipped and the ratio is applied at the following wrap, 8 cycles later.
- Second request held valid during PEND/SETTLE: `n_req_ready`=0 throughout. The request is accepted on the first RUN cycle and applied at the next wrap.
- Request `n_req_val`=1:
  - With the macro: `err` pulses once and `n_cur` stays 8.
  - Without the macro: `n_cur` becomes 2.
- `rst_n` pulsed low mid-SETTLE: outputs return to reset values asynchronously, `n_cur`=8, and the pending ratio is lost.

Source files
------------

// File: rtl/fd_n_pkg.sv
// +--------------------------------------------------------------------------+
// | fd_n_pkg : shared types and constants for the FD_N divider controller.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package fd_n_pkg;

  localparam int FD_N_W      = 4;
  localparam int FD_N_MIN    = 2;
  localparam int FD_SETTLE_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } fd_ctrl_state_t;

  // Ratios below the minimum would make the divider output degenerate.
  function automatic logic [FD_N_W-1:0] fd_n_clamp(input logic [FD_N_W-1:0] n);
    return (n < FD_N_W'(FD_N_MIN)) ? FD_N_W'(FD_N_MIN) : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fd_n_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | fd_n_ctrl_if : valid/ready ratio-change request channel.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fd_n_ctrl_if;
  import fd_n_pkg::*;

  logic              n_req_valid;
  logic [FD_N_W-1:0] n_req_val;
  logic              n_req_ready;

  modport master (output n_req_valid, output n_req_val, input n_req_ready);
  modport slave  (input n_req_valid, input n_req_val, output n_req_ready);

endinterface

`default_nettype wire

// File: rtl/fd_n_modcnt.sv
// +--------------------------------------------------------------------------+
// | fd_n_modcnt : 1..N modulus counter with synchronous load-to-1 and wrap.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module fd_n_modcnt
  import fd_n_pkg::*;
(
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic [FD_N_W-1:0] n_cur,
  input  logic              load,
  output logic [FD_N_W-1:0] n_counter,
  output logic              wrap
);

  logic [FD_N_W-1:0] r_cnt;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= FD_N_W'(1);
    end else if (load || wrap) begin
      r_cnt <= FD_N_W'(1);
    end else begin
      r_cnt <= r_cnt + FD_N_W'(1);
    end
  end

  assign wrap      = (r_cnt == n_cur);
  assign n_counter = r_cnt;

endmodule

`default_nettype wire

// File: rtl/fd_n_ctrl.sv
// +--------------------------------------------------------------------------+
// | fd_n_ctrl : N-divider sequencing controller (ratio apply at wrap, settle |
// |             window). Optional range check: FD_N_CTRL_RANGE_CHK_EN.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module fd_n_ctrl
  import fd_n_pkg::*;
#(
  parameter logic [FD_N_W-1:0] N_RESET    = 4'd8,
  parameter int                SETTLE_CYC = 8
) (
  input  logic              clk_out,
  input  logic              rst_n,
  fd_n_ctrl_if.slave        req,
  output logic [FD_N_W-1:0] n_cur,
  output logic [FD_N_W-1:0] n_counter,
  output logic              wrap,
  output logic              settled
`ifdef FD_N_CTRL_RANGE_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [FD_SETTLE_W-1:0] c_settle_init = FD_SETTLE_W'(SETTLE_CYC - 1);

  fd_ctrl_state_t         r_state,      w_state_nxt;
  logic [FD_N_W-1:0]      r_n_cur,      w_n_cur_nxt;
  logic [FD_N_W-1:0]      r_n_pend,     w_n_pend_nxt;
  logic [FD_SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
  logic                   w_load;
  logic                   w_ready;

`ifdef FD_N_CTRL_RANGE_CHK_EN
  logic r_err, w_err_nxt;
  logic w_req_bad;
  assign w_req_bad = (req.n_req_val < FD_N_W'(FD_N_MIN));
`endif

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_n_cur      <= N_RESET;
      r_n_pend     <= N_RESET;
      r_settle_cnt <= '0;
`ifdef FD_N_CTRL_RANGE_CHK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_n_cur      <= w_n_cur_nxt;
      r_n_pend     <= w_n_pend_nxt;
      r_settle_cnt <= w_settle_nxt;
`ifdef FD_N_CTRL_RANGE_CHK_EN
      r_err        <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_n_cur_nxt  = r_n_cur;
    w_n_pend_nxt = r_n_pend;
    w_settle_nxt = r_settle_cnt;
    w_load       = 1'b0;
`ifdef FD_N_CTRL_RANGE_CHK_EN
    w_err_nxt    = 1'b0;
`endif
    case (r_state)
      RUN: begin
        if (req.n_req_valid && w_ready) begin
`ifdef FD_N_CTRL_RANGE_CHK_EN
          if (w_req_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_n_pend_nxt = req.n_req_val;
            w_state_nxt  = PEND;
          end
`else
          w_n_pend_nxt = fd_n_clamp(req.n_req_val);
          w_state_nxt  = PEND;
`endif
        end
      end
      PEND: begin
        // Apply only at a wrap so the divided clock never emits a runt pulse.
        if (wrap) begin
          w_n_cur_nxt  = r_n_pend;
          w_load       = 1'b1;
          w_settle_nxt = c_settle_init;
          w_state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_settle_nxt = r_settle_cnt - FD_SETTLE_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  fd_n_modcnt u_modcnt (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .n_cur     (r_n_cur),
    .load      (w_load),
    .n_counter (n_counter),
    .wrap      (wrap)
  );

  assign w_ready         = (r_state == RUN);
  assign req.n_req_ready = w_ready;
  assign settled         = w_ready;
  assign n_cur           = r_n_cur;
`ifdef FD_N_CTRL_RANGE_CHK_EN
  assign err             = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fd_n_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_fd_n_ctrl : self-checking bench for fd_n_ctrl (N_RESET=8, SETTLE=8).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fd_n_ctrl;

  typedef struct {
    logic       v;
    logic [3:0] val;
    logic [3:0] cnt;
    logic [3:0] n;
    logic       wr;
    logic       st;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic [3:0] n;
    logic       wr;
    logic       st;
  } exp_t;

  logic       clk_out;
  logic       rst_n;
  logic [3:0] n_cur;
  logic [3:0] n_counter;
  logic       wrap;
  logic       settled;
`ifdef FD_N_CTRL_RANGE_CHK_EN
  logic       err;
`endif

  int   n_pass;
  int   n_total;
  exp_t sb[$];
  vec_t tbl[18];

  fd_n_ctrl_if bus ();

  fd_n_ctrl #(.N_RESET(4'd8), .SETTLE_CYC(8)) dut (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .req       (bus),
    .n_cur     (n_cur),
    .n_counter (n_counter),
    .wrap      (wrap),
    .settled   (settled)
`ifdef FD_N_CTRL_RANGE_CHK_EN
    ,
    .err       (err)
`endif
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  task automatic cmp(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input logic v, input logic [3:0] val);
    @(negedge clk_out);
    bus.n_req_valid = v;
    bus.n_req_val   = val;
    @(posedge clk_out);
    #1;
  endtask

  // Expected state is queued as the stimulus goes in and retired after the edge.
  task automatic step_chk(input string tag, input logic v, input logic [3:0] val, input exp_t e);
    exp_t x;
    sb.push_back(e);
    tick(v, val);
    x = sb.pop_front();
    cmp({tag, ".n_counter"}, int'(n_counter), int'(x.cnt));
    cmp({tag, ".n_cur"}, int'(n_cur), int'(x.n));
    cmp({tag, ".wrap"}, int'(wrap), int'(x.wr));
    cmp({tag, ".settled"}, int'(settled), int'(x.st));
    cmp({tag, ".ready"}, int'(bus.n_req_ready), int'(x.st));
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] val, input logic [3:0] cnt,
                              input logic [3:0] n, input logic wr, input logic st);
    vec_t r;
    r.v = v; r.val = val; r.cnt = cnt; r.n = n; r.wr = wr; r.st = st;
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    cmp({tag, ".n_cur"}, int'(n_cur), 8);
    cmp({tag, ".n_counter"}, int'(n_counter), 1);
    cmp({tag, ".wrap"}, int'(wrap), 0);
    cmp({tag, ".settled"}, int'(settled), 1);
    cmp({tag, ".ready"}, int'(bus.n_req_ready), 1);
`ifdef FD_N_CTRL_RANGE_CHK_EN
    cmp({tag, ".err"}, int'(err), 0);
`endif
  endtask

  task automatic wait_settled(input string tag);
    int k;
    k = 0;
    while (!settled && k < 30) begin
      tick(1'b0, 4'd0);
      k++;
    end
    cmp({tag, ".settle_bound"}, int'(settled), 1);
  endtask

  initial begin
    exp_t e;
    int   k;
    n_pass  = 0;
    n_total = 0;

    // Request 5 accepted at counter 3 with ratio 8: apply after counter 8,
    // eight cycles of settle, then period 5.
    tbl[0]  = mk(1'b0, 4'd0, 4'd2, 4'd8, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 4'd0, 4'd3, 4'd8, 1'b0, 1'b1);
    tbl[2]  = mk(1'b1, 4'd5, 4'd4, 4'd8, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 4'd0, 4'd5, 4'd8, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 4'd0, 4'd6, 4'd8, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 4'd0, 4'd7, 4'd8, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 4'd0, 4'd8, 4'd8, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 4'd0, 4'd2, 4'd5, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 4'd0, 4'd3, 4'd5, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 4'd0, 4'd4, 4'd5, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 4'd0, 4'd5, 4'd5, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 4'd0, 4'd2, 4'd5, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 4'd0, 4'd3, 4'd5, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 4'd0, 4'd4, 4'd5, 1'b0, 1'b1);
    tbl[16] = mk(1'b0, 4'd0, 4'd5, 4'd5, 1'b1, 1'b1);
    tbl[17] = mk(1'b0, 4'd0, 4'd1, 4'd5, 1'b0, 1'b1);

    rst_n           = 1'b0;
    bus.n_req_valid = 1'b0;
    bus.n_req_val   = 4'd0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk_out);
    #1;
    rst_n = 1'b1;

    // Idle: counter 1..8, wrap on every 8th cycle.
    for (int i = 1; i <= 16; i++) begin
      e.cnt = 4'((i % 8) + 1);
      e.n   = 4'd8;
      e.wr  = (e.cnt == 4'd8);
      e.st  = 1'b1;
      step_chk("idle", 1'b0, 4'd0, e);
    end

    for (int i = 0; i < 18; i++) begin
      e.cnt = tbl[i].cnt;
      e.n   = tbl[i].n;
      e.wr  = tbl[i].wr;
      e.st  = tbl[i].st;
      step_chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].val, e);
    end

    // Accept on the wrap cycle: that wrap is skipped, apply at the next one.
    for (int i = 0; i < 4; i++) tick(1'b0, 4'd0);
    cmp("onwrap.wrap_before", int'(wrap), 1);
    tick(1'b1, 4'd8);
    cmp("onwrap.ready", int'(bus.n_req_ready), 0);
    cmp("onwrap.n_unchanged", int'(n_cur), 5);
    k = 0;
    while (n_cur != 4'd8 && k < 20) begin
      tick(1'b0, 4'd0);
      k++;
    end
    cmp("onwrap.latency", k, 5);
    cmp("onwrap.counter_restart", int'(n_counter), 1);

    // Request held through SETTLE: never ready, accepted on the first RUN cycle.
    k = 0;
    while (!settled && k < 20) begin
      tick(1'b1, 4'd3);
      k++;
      if (!settled) cmp("hold.ready_low", int'(bus.n_req_ready), 0);
    end
    cmp("hold.settle_len", k, 8);
    tick(1'b1, 4'd3);
    cmp("hold.accepted", int'(bus.n_req_ready), 0);
    k = 0;
    while (n_cur != 4'd3 && k < 20) begin
      tick(1'b0, 4'd0);
      k++;
    end
    cmp("hold.latency", k, 7);
    cmp("hold.counter_restart", int'(n_counter), 1);

    // Illegal ratio 1.
    wait_settled("ill");
`ifdef FD_N_CTRL_RANGE_CHK_EN
    tick(1'b1, 4'd1);
    cmp("ill.err_pulse", int'(err), 1);
    cmp("ill.still_run", int'(settled), 1);
    cmp("ill.n_kept", int'(n_cur), 3);
    tick(1'b0, 4'd0);
    cmp("ill.err_clear", int'(err), 0);
    cmp("ill.n_kept2", int'(n_cur), 3);
`else
    tick(1'b1, 4'd1);
    cmp("ill.accepted", int'(bus.n_req_ready), 0);
    k = 0;
    while (n_cur == 4'd3 && k < 10) begin
      tick(1'b0, 4'd0);
      k++;
    end
    cmp("ill.clamped", int'(n_cur), 2);
    cmp("ill.counter_restart", int'(n_counter), 1);
`endif

    // Asynchronous reset mid-SETTLE.
    wait_settled("rst1");
    tick(1'b1, 4'd5);
    k = 0;
    while (n_cur != 4'd5 && k < 20) begin
      tick(1'b0, 4'd0);
      k++;
    end
    tick(1'b0, 4'd0);
    tick(1'b0, 4'd0);
    cmp("rst1.in_settle", int'(settled), 0);
    @(posedge clk_out);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst1.async");
    @(posedge clk_out);
    #1;
    rst_n = 1'b1;

    // Asynchronous reset mid-PEND loses the pending ratio.
    tick(1'b1, 4'd4);
    tick(1'b0, 4'd0);
    cmp("rst2.in_pend", int'(bus.n_req_ready), 0);
    @(posedge clk_out);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst2.async");
    @(posedge clk_out);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick(1'b0, 4'd0);
    cmp("rst2.n_lost", int'(n_cur), 8);
    cmp("rst2.settled", int'(settled), 1);
    cmp("rst2.counter", int'(n_counter), 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
